multiciclo_core: RTL and testbench

- Multicycle successor to the single-cycle core. Executes the RV32I subset: R-type ALU, I-type ALU, LW, SW, and optionally BEQ/BNE/JAL.
- A central FSM shares one ALU across fetch, decode, execute, memory and write-back.
- Instruction and data memories are external and use req/ack handshakes, so wait-stated memories are tolerated.
- salida_o exposes the last write-back value.

---
 rtl/multiciclo_core_if.sv | 35 +++
 rtl/multiciclo_core.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_multiciclo_core.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/multiciclo_core_if.sv
// Memory-side bus of multiciclo_core: instruction fetch port and data port,
// each with a req/ack handshake. Signal names carry the direction as seen
// from the core (the master side).
interface multiciclo_core_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 8
);
    // Instruction port
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_ack_i;
    logic [31:0]       imem_data_i;

    // Data port
    logic              dmem_req_o;
    logic              dmem_we_o;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic [XLEN-1:0]   dmem_wdata_o;
    logic              dmem_ack_i;
    logic [XLEN-1:0]   dmem_rdata_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_ack_i, imem_data_i,
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_ack_i, dmem_rdata_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_ack_i, imem_data_i,
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output dmem_ack_i, dmem_rdata_i
    );
endinterface

// File: rtl/multiciclo_core.sv
// multiciclo_core: multicycle RV32I-subset core (R-type ALU, I-type ALU, LW,
// SW). One ALU is shared by all FSM phases; instruction and data memories
// sit behind req/ack handshakes so wait states are tolerated.
// Optional feature macro: MULTICICLO_BRANCH_EN adds BEQ/BNE and JAL. Without
// it, opcodes 1100011 and 1101111 decode as illegal and halt the core.
module multiciclo_core #(
    parameter int          XLEN     = 32,
    parameter int          ADDR_W   = 8,
    parameter int unsigned RESET_PC = 32'd0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    multiciclo_core_if.master bus,
    output logic [XLEN-1:0]   salida_o,
    output logic              retire_o,
    output logic              halt_o
);

    localparam int              SH_W       = $clog2(XLEN);
    localparam logic [XLEN-1:0] RESET_PC_X = XLEN'(RESET_PC);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Shared ALU; op is {funct7[5], funct3}. SUB/SRA need bit 3, all other
    // operations ignore it.
    function automatic logic [XLEN-1:0] alu_f(input logic [3:0]      op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        r = '0;
        case (op)
            4'b0000:          r = a + b;
            4'b1000:          r = a - b;
            4'b0001, 4'b1001: r = a << b[SH_W-1:0];
            4'b0010, 4'b1010: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0011, 4'b1011: r = {{(XLEN-1){1'b0}}, (a < b)};
            4'b0100, 4'b1100: r = a ^ b;
            4'b0101:          r = a >> b[SH_W-1:0];
            4'b1101:          r = $unsigned($signed(a) >>> b[SH_W-1:0]);
            4'b0110, 4'b1110: r = a | b;
            4'b0111, 4'b1111: r = a & b;
            default:          r = '0;
        endcase
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] a_q, b_q, imm_q, aluout_q, mdr_q, salida_q;
    logic [XLEN-1:0] rf_q [0:31];

    logic [6:0]        opcode_s;
    logic [2:0]        funct3_s;
    logic [4:0]        rd_s, rs1_s, rs2_s;
    logic              is_r_s, is_i_s, is_ld_s, is_st_s, is_br_s, is_jal_s;
    logic              illegal_s;
    logic signed [31:0] imm32_s;
    logic [XLEN-1:0]   imm_s;
    logic [XLEN-1:0]   rs1_val_s, rs2_val_s;
    logic [XLEN-1:0]   alu_a_s, alu_b_s, alu_s;
    logic [3:0]        alu_op_s;
    logic [XLEN-1:0]   pc_plus4_s, wb_result_s;
    logic              br_taken_s;
    logic              retire_s;
    logic              imem_req_s, dmem_req_s;

    assign opcode_s = ir_q[6:0];
    assign funct3_s = ir_q[14:12];
    assign rd_s     = ir_q[11:7];
    assign rs1_s    = ir_q[19:15];
    assign rs2_s    = ir_q[24:20];

    assign is_r_s   = (opcode_s == OP_R);
    assign is_i_s   = (opcode_s == OP_I);
    assign is_ld_s  = (opcode_s == OP_LOAD);
    assign is_st_s  = (opcode_s == OP_STORE);
`ifdef MULTICICLO_BRANCH_EN
    assign is_br_s  = (opcode_s == OP_BRANCH);
    assign is_jal_s = (opcode_s == OP_JAL);
`else
    assign is_br_s  = 1'b0;
    assign is_jal_s = 1'b0;
`endif

    assign rs1_val_s   = (rs1_s == 5'd0) ? '0 : rf_q[rs1_s];
    assign rs2_val_s   = (rs2_s == 5'd0) ? '0 : rf_q[rs2_s];
    assign pc_plus4_s  = pc_q + XLEN'(4);
    assign br_taken_s  = (a_q == b_q) ^ funct3_s[0];
    assign alu_s       = alu_f(alu_op_s, alu_a_s, alu_b_s);
    assign wb_result_s = is_ld_s  ? mdr_q :
                         is_jal_s ? pc_plus4_s : aluout_q;

    // Legality check: opcode plus funct3 where the opcode restricts it.
    always_comb begin
        illegal_s = 1'b1;
        case (opcode_s)
            OP_R:     illegal_s = 1'b0;
            OP_I:     illegal_s = 1'b0;
            OP_LOAD:  illegal_s = (funct3_s != 3'b010);
            OP_STORE: illegal_s = (funct3_s != 3'b010);
`ifdef MULTICICLO_BRANCH_EN
            OP_BRANCH: illegal_s = (funct3_s != 3'b000) && (funct3_s != 3'b001);
            OP_JAL:    illegal_s = 1'b0;
`endif
            default:  illegal_s = 1'b1;
        endcase
    end

    // Immediate extraction by format, then sign extension to XLEN.
    always_comb begin
        imm32_s = '0;
        case (opcode_s)
            OP_STORE:  imm32_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            OP_BRANCH: imm32_s = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                                  ir_q[30:25], ir_q[11:8], 1'b0};
            OP_JAL:    imm32_s = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                                  ir_q[20], ir_q[30:21], 1'b0};
            default:   imm32_s = {{20{ir_q[31]}}, ir_q[31:20]};
        endcase
        imm_s = XLEN'(imm32_s);
    end

    // ALU operand/op selection: PC+IMM during DECODE (branch/jump target),
    // the instruction's own operation during EXEC.
    always_comb begin
        alu_a_s  = a_q;
        alu_b_s  = b_q;
        alu_op_s = ALU_ADD;
        case (state_q)
            S_DECODE: begin
                alu_a_s = pc_q;
                alu_b_s = imm_s;
            end
            S_EXEC: begin
                if (is_r_s) begin
                    alu_op_s = {ir_q[30], funct3_s};
                end else if (is_i_s) begin
                    alu_b_s  = imm_q;
                    alu_op_s = {(funct3_s == 3'b101) & ir_q[30], funct3_s};
                end else begin
                    alu_b_s  = imm_q;
                end
            end
            default: begin
                alu_a_s = a_q;
            end
        endcase
    end

    // FSM next state and retire pulse.
    always_comb begin
        state_d  = state_q;
        retire_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ack_i) state_d = S_DECODE;
                else                state_d = S_FETCH;
            end
            S_DECODE: begin
                if (illegal_s) state_d = S_HALT;
                else           state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_ld_s || is_st_s) begin
                    state_d = S_MEM;
                end else if (is_br_s) begin
                    state_d  = S_FETCH;
                    retire_s = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (bus.dmem_ack_i) begin
                    if (is_st_s) begin
                        state_d  = S_FETCH;
                        retire_s = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    // Datapath registers updated according to the current phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q     <= RESET_PC_X;
            ir_q     <= 32'd0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
            salida_q <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (bus.imem_ack_i) ir_q <= bus.imem_data_i;
                end
                S_DECODE: begin
                    a_q   <= rs1_val_s;
                    b_q   <= rs2_val_s;
                    imm_q <= imm_s;
`ifdef MULTICICLO_BRANCH_EN
                    aluout_q <= alu_s;
`endif
                end
                S_EXEC: begin
                    if (is_br_s) begin
                        pc_q <= br_taken_s ? aluout_q : pc_plus4_s;
                    end else if (!is_jal_s) begin
                        aluout_q <= alu_s;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ack_i) begin
                        if (is_st_s) pc_q  <= pc_plus4_s;
                        else         mdr_q <= bus.dmem_rdata_i;
                    end
                end
                S_WB: begin
                    salida_q <= wb_result_s;
                    pc_q     <= is_jal_s ? aluout_q : pc_plus4_s;
                end
                default: begin
                    pc_q <= pc_q;
                end
            endcase
        end
    end

    // Register file write port; x0 is never written and stays zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if ((state_q == S_WB) && (rd_s != 5'd0)) begin
            rf_q[rd_s] <= wb_result_s;
        end
    end

    // Requests are decoded from the state register; the fetch request is
    // also qualified by reset so every output is low while reset is held.
    assign imem_req_s = (state_q == S_FETCH) && rst_ni;
    assign dmem_req_s = (state_q == S_MEM);

    assign bus.imem_req_o   = imem_req_s;
    assign bus.imem_addr_o  = imem_req_s ? pc_q[ADDR_W-1:0] : '0;
    assign bus.dmem_req_o   = dmem_req_s;
    assign bus.dmem_we_o    = dmem_req_s & is_st_s;
    assign bus.dmem_addr_o  = dmem_req_s ? {aluout_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.dmem_wdata_o = (dmem_req_s && is_st_s) ? b_q : '0;

    assign salida_o = salida_q;
    assign retire_o = retire_s;
    assign halt_o   = (state_q == S_HALT);

endmodule

// File: tb/tb_multiciclo_core.sv
// Directed, table-driven bench for multiciclo_core with req/ack memory models
// whose wait states are programmable per instruction.
module tb_multiciclo_core;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 8;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [XLEN-1:0] salida;
    logic            retire, halt;

    always #5 clk = ~clk;

    multiciclo_core_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    multiciclo_core #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RESET_PC(0)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .bus      (bus),
        .salida_o (salida),
        .retire_o (retire),
        .halt_o   (halt)
    );

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:63];
    int idly, ddly, icnt, dcnt;
    int n_checks = 0;
    int n_errors = 0;

    assign bus.imem_ack_i   = bus.imem_req_o && (icnt == idly);
    assign bus.imem_data_i  = imem[bus.imem_addr_o[7:2]];
    assign bus.dmem_ack_i   = bus.dmem_req_o && (dcnt == ddly);
    assign bus.dmem_rdata_i = dmem[bus.dmem_addr_o[7:2]];

    always @(posedge clk) begin
        if (!bus.imem_req_o || bus.imem_ack_i) icnt <= 0;
        else                                   icnt <= icnt + 1;
        if (!bus.dmem_req_o || bus.dmem_ack_i) dcnt <= 0;
        else                                   dcnt <= dcnt + 1;
        if (bus.dmem_req_o && bus.dmem_we_o && bus.dmem_ack_i)
            dmem[bus.dmem_addr_o[7:2]] <= bus.dmem_wdata_o;
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] exp_salida;
        int          exp_cycles;
        int          iwait;
        int          dwait;
        bit          mem;
        logic        exp_we;
        logic [7:0]  exp_daddr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] exp_s,
                                input int cyc, input int iw, input int dw,
                                input bit mem, input logic we, input logic [31:0] wd);
        vec_t v;
        v.instr = instr; v.exp_salida = exp_s; v.exp_cycles = cyc;
        v.iwait = iw; v.dwait = dw; v.mem = mem; v.exp_we = we;
        v.exp_daddr = 8'h08; v.exp_wdata = wd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one instruction from its FETCH cycle until retire, checking the
    // fetch address, data-port behaviour, latency and salida_o.
    task automatic run_vec(input vec_t v, input logic [7:0] pc, input string name);
        int cyc;
        bit done;
        idly = v.iwait;
        ddly = v.dwait;
        cyc  = 0;
        done = 1'b0;
        #1;
        while (!done && cyc < 50) begin
            cyc++;
            if (cyc == 1) begin
                check({name, "/ireq"}, 32'(bus.imem_req_o), 32'd1);
                check({name, "/iaddr"}, 32'(bus.imem_addr_o), 32'(pc));
            end
            if (bus.imem_req_o && bus.dmem_req_o)
                check({name, "/excl"}, 32'd1, 32'd0);
            if (bus.dmem_req_o) begin
                check({name, "/dreq_ok"}, 32'(v.mem), 32'd1);
                check({name, "/daddr"}, 32'(bus.dmem_addr_o), 32'(v.exp_daddr));
                check({name, "/dwe"}, 32'(bus.dmem_we_o), 32'(v.exp_we));
                if (v.exp_we) check({name, "/dwdata"}, bus.dmem_wdata_o, v.exp_wdata);
            end
            if (retire) done = 1'b1;
            @(negedge clk);
        end
        check({name, "/retired"}, 32'(done), 32'd1);
        if (done) begin
            check({name, "/cycles"}, 32'(cyc), 32'(v.exp_cycles));
            check({name, "/salida"}, salida, v.exp_salida);
        end
        idly = 0;
        ddly = 0;
    endtask

    // Waits (bounded) for halt_o, then checks the core stays quiet.
    task automatic wait_halt(input int exp_cyc, input string name);
        int  cyc;
        bit  seen;
        cyc  = 0;
        seen = 1'b0;
        #1;
        while (!seen && cyc < 10) begin
            cyc++;
            if (halt) seen = 1'b1;
            else      @(negedge clk);
        end
        check({name, "/halt_seen"}, 32'(seen), 32'd1);
        check({name, "/halt_cyc"}, 32'(cyc), 32'(exp_cyc));
        for (int k = 0; k < 10; k++) begin
            check({name, "/quiet"},
                  {28'd0, halt, bus.imem_req_o, bus.dmem_req_o, retire}, 32'h8);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0;
        idly   = 0;
        ddly   = 0;
        for (int i = 0; i < 64; i++) begin
            imem[i] = 32'h0000007F;
            dmem[i] = 32'hDEADBEEF;
        end
        //               instr          salida        cyc iw dw mem we wdata
        vecs[0]  = mk(32'h00500093, 32'h00000005, 4, 0, 0, 0, 0, 0);  // addi x1,x0,5
        vecs[1]  = mk(32'hFFD00113, 32'hFFFFFFFD, 4, 0, 0, 0, 0, 0);  // addi x2,x0,-3
        vecs[2]  = mk(32'h002081B3, 32'h00000002, 4, 0, 0, 0, 0, 0);  // add x3,x1,x2
        vecs[3]  = mk(32'h00302423, 32'h00000002, 7, 0, 3, 1, 1, 2);  // sw x3,8(x0)
        vecs[4]  = mk(32'h00802203, 32'h00000002, 8, 0, 3, 1, 0, 0);  // lw x4,8(x0)
        vecs[5]  = mk(32'h401002B3, 32'hFFFFFFFB, 4, 0, 0, 0, 0, 0);  // sub x5,x0,x1
        vecs[6]  = mk(32'h4012D313, 32'hFFFFFFFD, 4, 0, 0, 0, 0, 0);  // srai x6,x5,1
        vecs[7]  = mk(32'h005033B3, 32'h00000001, 4, 0, 0, 0, 0, 0);  // sltu x7,x0,x5
        vecs[8]  = mk(32'h00700013, 32'h00000007, 4, 0, 0, 0, 0, 0);  // addi x0,x0,7
        vecs[9]  = mk(32'h00100413, 32'h00000001, 4, 0, 0, 0, 0, 0);  // addi x8,x0,1
        vecs[10] = mk(32'h0020C4B3, 32'hFFFFFFF8, 6, 2, 0, 0, 0, 0);  // xor x9,x1,x2
        vecs[11] = mk(32'h00112533, 32'h00000001, 4, 0, 0, 0, 0, 0);  // slt x10,x2,x1
        vecs[12] = mk(32'h00409593, 32'h00000050, 4, 0, 0, 0, 0, 0);  // slli x11,x1,4
        vecs[13] = mk(32'h01C15613, 32'h0000000F, 4, 0, 0, 0, 0, 0);  // srli x12,x2,28
        vecs[14] = mk(32'h0020F6B3, 32'h00000005, 4, 0, 0, 0, 0, 0);  // and x13,x1,x2
        vecs[15] = mk(32'h00528793, 32'h00000000, 4, 0, 0, 0, 0, 0);  // addi x15,x5,5
        vecs[16] = mk(32'h10026713, 32'h00000102, 5, 1, 0, 0, 0, 0);  // ori x14,x4,0x100
        for (int i = 0; i < 17; i++) imem[i] = vecs[i].instr;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst/ireq", 32'(bus.imem_req_o), 32'd0);
        check("rst/dreq", 32'(bus.dmem_req_o), 32'd0);
        check("rst/salida", salida, 32'd0);
        check("rst/flags", {30'd0, retire, halt}, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < 17; i++)
            run_vec(vecs[i], 8'(4 * i), $sformatf("v%0d", i));

        // Reset asserted while a fetch is stalled waiting for ack
        idly = 10;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("midwait/ireq", {31'd0, bus.imem_req_o}, 32'd1);
            check("midwait/iaddr", 32'(bus.imem_addr_o), 32'h44);
            @(negedge clk);
            #1;
        end
        rst_ni = 1'b0;
        #1;
        check("midrst/ireq", 32'(bus.imem_req_o), 32'd0);
        check("midrst/iaddr", 32'(bus.imem_addr_o), 32'd0);
        check("midrst/dmem", {22'd0, bus.dmem_req_o, bus.dmem_we_o, bus.dmem_addr_o}, 32'd0);
        check("midrst/wdata", bus.dmem_wdata_o, 32'd0);
        check("midrst/salida", salida, 32'd0);
        check("midrst/flags", {30'd0, retire, halt}, 32'd0);
        idly = 0;
        imem[0] = 32'h00500093;  // addi x1,x0,5
        imem[1] = 32'h00018833;  // add x16,x3,x0 (x3 cleared by reset)
        imem[2] = 32'h0000007F;  // illegal
        @(negedge clk);
        rst_ni = 1'b1;
        run_vec(mk(32'h00500093, 32'h5, 4, 0, 0, 0, 0, 0), 8'h00, "r0");
        run_vec(mk(32'h00018833, 32'h0, 4, 0, 0, 0, 0, 0), 8'h04, "r1");
        wait_halt(3, "illegal");

        // Branch/jump sequence at 0x10
        rst_ni = 1'b0;
        for (int i = 0; i < 4; i++) imem[i] = 32'h00000013;  // nop
        imem[4] = 32'hFE000EE3;                             // beq x0,x0,-4
        imem[5] = 32'h00108113;                             // addi x2,x1,1
        imem[6] = 32'hFE001EE3;                             // bne x0,x0,-4
        imem[7] = 32'h00000013;
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++)
            run_vec(mk(32'h00000013, 32'h0, 4, 0, 0, 0, 0, 0), 8'(4 * i), $sformatf("nop%0d", i));
`ifdef MULTICICLO_BRANCH_EN
        run_vec(mk(32'hFE000EE3, 32'h0, 3, 0, 0, 0, 0, 0), 8'h10, "beq");
        imem[3] = 32'h008000EF;                             // jal x1,+8
        run_vec(mk(32'h008000EF, 32'h10, 4, 0, 0, 0, 0, 0), 8'h0C, "jal");
        run_vec(mk(32'h00108113, 32'h11, 4, 0, 0, 0, 0, 0), 8'h14, "after_jal");
        run_vec(mk(32'hFE001EE3, 32'h11, 3, 0, 0, 0, 0, 0), 8'h18, "bne_nt");
        run_vec(mk(32'h00000013, 32'h0, 4, 0, 0, 0, 0, 0), 8'h1C, "after_bne");
`else
        wait_halt(3, "beq_illegal");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
